ram_nway: RTL and testbench
===========================

RAM_NWAY -- requirements
Module: ram_nway

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning data word width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning number of words (power of two, >=2).
REQ-003 The module SHALL derive localparam ADDR_W = $clog2(DEPTH); it is not user-overridable.
REQ-004 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-006 The module SHALL have port in  input  WIDTH  meaning write data.
REQ-007 The module SHALL have port load  input  1  meaning write enable.
REQ-008 The module SHALL have port address  input  ADDR_W  meaning read/write word index.
REQ-009 The module SHALL have port clear  input  1  meaning a request to zero all words.
REQ-010 The module SHALL have port out  output  WIDTH  meaning read data.
REQ-011 The module SHALL have port busy  output  1  meaning a clear sweep is in progress.

Function
REQ-012 The FSM SHALL have two states, CLEAR and IDLE, plus an ADDR_W-bit sweep pointer ptr.
REQ-013 In IDLE, out SHALL be the combinational value mem[address], with no clock latency, and busy SHALL be 0.
REQ-014 In IDLE with load=1, clear=0 and rst=0, the rising edge SHALL write mem[address] <= in; out shows the new value from the next cycle.
REQ-015 In IDLE with load=0, memory SHALL hold; out SHALL follow address changes within the same cycle.
REQ-016 In IDLE with clear=1, the edge SHALL enter CLEAR with ptr=0; a simultaneous load SHALL be dropped, because clear has priority.
REQ-017 In CLEAR, each rising edge SHALL write mem[ptr] <= 0 and increment ptr.
REQ-018 In CLEAR, the edge that writes ptr=DEPTH-1 SHALL transition to IDLE; ptr wraps to 0.
REQ-019 In CLEAR, busy SHALL be 1 and out SHALL be 0, regardless of address and contents.
REQ-020 In CLEAR, load and clear SHALL be ignored; the sweep is not restarted or extended.
REQ-021 A full sweep SHALL take exactly DEPTH cycles from entering CLEAR to busy=0.
REQ-022 Only address bits [ADDR_W-1:0] SHALL exist; there is no out-of-range case.

Reset
REQ-023 rst=1 at a rising edge SHALL force state CLEAR with ptr=0, and no memory write occurs on that edge.
REQ-024 While rst is held high, the sweep SHALL not advance, busy SHALL be 1, and out SHALL be 0.
REQ-025 After rst deasserts, the sweep SHALL run for DEPTH edges, then busy=0 with all words equal to 0.
REQ-026 rst asserted mid-sweep or mid-operation SHALL restart the sweep from ptr=0.
REQ-027 rst SHALL take priority over clear and load.

Configuration
REQ-028 The module SHALL support macro RAM_NWAY_WRITE_THROUGH_EN.
REQ-029 With RAM_NWAY_WRITE_THROUGH_EN defined, in IDLE with load=1 and clear=0, out SHALL equal in combinationally, before the edge.
REQ-030 Without RAM_NWAY_WRITE_THROUGH_EN, out SHALL always show the stored mem[address], which is the old value during a write cycle.
REQ-031 In neither configuration SHALL the macro change CLEAR or reset behaviour.

Verification (WIDTH=16, DEPTH=8 unless stated)
REQ-032 The bench SHALL cover: rst 1 cycle, then idle -> busy=1 and out=0 for 8 cycles; then busy=0, and reads of addresses 0..7 all return 16'h0000.
REQ-033 The bench SHALL cover: write 16'h1234 to address 3 and 16'hFEDC to address 7, then read addresses 3, 7 and 0 -> 16'h1234, 16'hFEDC, 16'h0000, each in the same cycle the address is applied.
REQ-034 The bench SHALL cover: load=1, address=5, in=16'hAAAA during IDLE -> out is 16'hAAAA in that cycle with the macro, and the old value 16'h0000 without it; the next cycle reads 16'hAAAA in both.
REQ-035 The bench SHALL cover: all words filled with 16'hFFFF, then clear=1 and load=1 to address 2 with 16'h5555 in the same cycle -> the load is dropped, busy=1 for 8 cycles, and afterwards all words read 16'h0000.
REQ-036 The bench SHALL cover: clear pulse, then rst asserted at sweep cycle 4 -> the sweep restarts, and busy=1 for 8 cycles after rst deasserts.
REQ-037 The bench SHALL cover: WIDTH=8, DEPTH=64, with 1000 random load/address/in cycles checked against a reference array -> no mismatch; then a clear zeros all 64 words in 64 cycles.

Source files
------------

// File: rtl/ram_nway.sv
// Word-addressable RAM with combinational read and a DEPTH-cycle clear sweep.
// Optional macro RAM_NWAY_WRITE_THROUGH_EN forwards write data to out during an idle write.
module ram_nway #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    we         = 1'b0;
    waddr      = address;
    wdata      = in;
    busy       = 1'b0;
    out        = mem[address];
    case (state)
      IDLE: begin
        // clear wins over a same-cycle load
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else if (load) begin
          we = 1'b1;
`ifdef RAM_NWAY_WRITE_THROUGH_EN
          out = in;
`endif
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        out      = '0;
        we       = 1'b1;
        waddr    = ptr;
        wdata    = '0;
        ptr_next = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
    // reset edges never write memory
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_ram_nway.sv
// Scoreboard bench for ram_nway: a 16x8 instance with directed vectors and an
// 8x64 instance with a random load/read run against a reference array.
module tb_ram_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_NWAY_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        a_rst, a_load, a_clear, a_busy;
  logic [2:0]  a_addr;
  logic [15:0] a_in, a_out;
  logic        b_rst, b_load, b_clear, b_busy;
  logic [5:0]  b_addr;
  logic [7:0]  b_in, b_out;

  ram_nway #(.WIDTH(16), .DEPTH(8)) dut_a (
    .clk(clk), .rst(a_rst), .in(a_in), .load(a_load), .address(a_addr),
    .clear(a_clear), .out(a_out), .busy(a_busy)
  );

  ram_nway #(.WIDTH(8), .DEPTH(64)) dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .load(b_load), .address(b_addr),
    .clear(b_clear), .out(b_out), .busy(b_busy)
  );

  typedef struct {
    int unsigned dut;
    logic [16:0] exp;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  logic [15:0] ref_a [8];
  logic [7:0]  ref_b [64];

  // Monitor: outputs are settled by the falling edge; compare everything queued this cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      string       n;
      logic [16:0] act;
      e   = q.pop_front();
      n   = nq.pop_front();
      act = (e.dut == 0) ? {a_busy, a_out} : {b_busy, 8'h00, b_out};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got busy=%0b out=%h, expected busy=%0b out=%h",
                 n, act[16], act[15:0], e.exp[16], e.exp[15:0]);
      end
    end
  end

  task automatic push_exp(input int unsigned dut, input string n, input logic bz, input logic [15:0] o);
    exp_t e;
    e.dut = dut;
    e.exp = {bz, o};
    q.push_back(e);
    nq.push_back(n);
  endtask

  task automatic drive_a(input logic r, input logic l, input logic c, input logic [2:0] ad, input logic [15:0] d);
    @(posedge clk);
    #1;
    a_rst = r; a_load = l; a_clear = c; a_addr = ad; a_in = d;
  endtask

  task automatic drive_b(input logic r, input logic l, input logic c, input logic [5:0] ad, input logic [7:0] d);
    @(posedge clk);
    #1;
    b_rst = r; b_load = l; b_clear = c; b_addr = ad; b_in = d;
  endtask

  task automatic a_write(input logic [2:0] ad, input logic [15:0] d);
    drive_a(1'b0, 1'b1, 1'b0, ad, d);
    push_exp(0, "a_write_cycle", 1'b0, WT ? d : ref_a[ad]);
    ref_a[ad] = d;
  endtask

  task automatic a_read(input logic [2:0] ad, input logic [15:0] exp_v, input string n);
    drive_a(1'b0, 1'b0, 1'b0, ad, 16'h0);
    push_exp(0, n, 1'b0, exp_v);
  endtask

  task automatic a_busy_cycles(input int unsigned n, input logic [2:0] ad, input string nm);
    for (int unsigned i = 0; i < n; i++) begin
      drive_a(1'b0, 1'b0, 1'b0, ad, 16'h0);
      push_exp(0, nm, 1'b1, 16'h0000);
    end
  endtask

  task automatic b_busy_cycles(input string nm);
    for (int unsigned i = 0; i < 64; i++) begin
      drive_b(1'b0, 1'b1, (i == 10), 6'(i), 8'h5A);
      push_exp(1, nm, 1'b1, 16'h0000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b0; a_load = 1'b0; a_clear = 1'b0; a_addr = '0; a_in = '0;
    b_rst = 1'b0; b_load = 1'b0; b_clear = 1'b0; b_addr = '0; b_in = '0;
    for (int i = 0; i < 8; i++) ref_a[i] = 16'h0000;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;

    // Reset, then an 8-cycle sweep that ignores load and clear
    drive_a(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b0, 1'b1, (i == 5), 3'd3, 16'hAAAA);
      push_exp(0, "a_reset_sweep", 1'b1, 16'h0000);
    end
    for (int i = 0; i < 8; i++) a_read(3'(i), 16'h0000, "a_after_reset");

    a_write(3'd3, 16'h1234);
    a_write(3'd7, 16'hFEDC);
    a_read(3'd3, 16'h1234, "a_read3");
    a_read(3'd7, 16'hFEDC, "a_read7");
    a_read(3'd0, 16'h0000, "a_read0");

    drive_a(1'b0, 1'b1, 1'b0, 3'd5, 16'hAAAA);
    push_exp(0, "a_write_through5", 1'b0, WT ? 16'hAAAA : 16'h0000);
    ref_a[5] = 16'hAAAA;
    a_read(3'd5, 16'hAAAA, "a_read5_next");

    // Fill, then clear with a colliding load that must be dropped
    for (int i = 0; i < 8; i++) a_write(3'(i), 16'hFFFF);
    drive_a(1'b0, 1'b1, 1'b1, 3'd2, 16'h5555);
    push_exp(0, "a_clear_load_cycle", 1'b0, 16'hFFFF);
    a_busy_cycles(8, 3'd2, "a_clear_sweep");
    for (int i = 0; i < 8; i++) a_read(3'(i), 16'h0000, "a_after_clear");
    for (int i = 0; i < 8; i++) ref_a[i] = 16'h0000;

    // Clear pulse, then rst at sweep cycle 4 (held two edges) restarts the sweep
    a_write(3'd6, 16'h6666);
    drive_a(1'b0, 1'b0, 1'b1, 3'd6, 16'h0);
    push_exp(0, "a_clear_pulse", 1'b0, 16'h6666);
    a_busy_cycles(3, 3'd6, "a_sweep_pre_rst");
    drive_a(1'b1, 1'b1, 1'b1, 3'd6, 16'h7777);
    push_exp(0, "a_rst_mid_sweep", 1'b1, 16'h0000);
    drive_a(1'b1, 1'b1, 1'b1, 3'd6, 16'h7777);
    push_exp(0, "a_rst_held", 1'b1, 16'h0000);
    a_busy_cycles(8, 3'd6, "a_sweep_restart");
    a_read(3'd6, 16'h0000, "a_after_restart");
    a_read(3'd3, 16'h0000, "a_after_restart3");

    // Wide instance: reset sweep, random traffic, full clear
    drive_b(1'b1, 1'b0, 1'b0, 6'd0, 8'h0);
    b_busy_cycles("b_reset_sweep");
    for (int i = 0; i < 1000; i++) begin
      logic       l;
      logic [5:0] ad;
      logic [7:0] d;
      l  = 1'($urandom_range(0, 1));
      ad = 6'($urandom_range(0, 63));
      d  = 8'($urandom_range(0, 255));
      drive_b(1'b0, l, 1'b0, ad, d);
      push_exp(1, "b_random", 1'b0, {8'h00, (WT && l) ? d : ref_b[ad]});
      if (l) ref_b[ad] = d;
    end
    drive_b(1'b0, 1'b0, 1'b1, 6'd9, 8'h0);
    push_exp(1, "b_clear_cycle", 1'b0, {8'h00, ref_b[9]});
    b_busy_cycles("b_clear_sweep");
    for (int i = 0; i < 64; i++) begin
      drive_b(1'b0, 1'b0, 1'b0, 6'(i), 8'h0);
      push_exp(1, "b_after_clear", 1'b0, 16'h0000);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (q.size() != 0) begin
      $display("FAIL pending: got %0d uncompared expectations, expected 0", q.size());
      $fatal(1);
    end
    if (checks < 12) begin
      $display("FAIL coverage: got %0d checks, expected at least 12", checks);
      $fatal(1);
    end
    if (errors != 0) begin
      $display("FAIL summary: got %0d errors, expected 0", errors);
      $fatal(1);
    end
    $display("PASS");
    $finish;
  end

endmodule
